// File: rtl/uart_pkg.sv
// Shared UART definitions: TX arbiter state encoding, frame-gap timing
// and the index-width helper used by the TX and RX arbiters.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } tx_arb_state_e;

    localparam int CLK_HZ     = 50_000_000;
    localparam int BAUD       = 115_200;
    localparam int BIT_CYCLES = CLK_HZ / BAUD;

    // two idle bit times let the receiver re-hunt for a start bit
    localparam int FRAME_GAP_CYCLES = 2 * BIT_CYCLES;
    localparam int DEF_GAP_CYCLES   = 1000;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational one-hot picker: fixed priority (lowest index) or
// round-robin search starting at ptr, selected by the RR parameter.
module uart_arb_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 2,
    parameter bit RR   = 1'b0,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0]   base;
    logic [NREQ-1:0] rot;
    logic [IW:0]     sum;
    logic            found;

    assign base = RR ? ptr : '0;

    always_comb begin
        rot   = NREQ'({req, req} >> base);
        gnt   = '0;
        idx   = '0;
        sum   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, base} + (IW+1)'(k);
                if (sum >= (IW+1)'(NREQ))
                    sum = sum - (IW+1)'(NREQ);
                idx = sum[IW-1:0];
            end
        end
        if (found)
            gnt = NREQ'(1) << idx;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular arbiter sharing one UART TX core between NREQ sources.
// Define UART_TX_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int GAP_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   src_valid,
    input  logic [8*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]   src_last,
    output logic [NREQ-1:0]   src_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              frame_done
);

    localparam int IW = idx_w(NREQ);

    tx_arb_state_e    state;
    logic [IW-1:0]    gnt_idx;
    logic             last_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [NREQ-1:0]  pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             accept;
    logic [IW-1:0]    rr_ptr;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (state == ST_IDLE && |src_valid)
            rr_ptr <= (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + IW'(1);
    end
`else
    localparam bit RR = 1'b0;

    assign rr_ptr = '0;
`endif

    uart_arb_pick #(
        .NREQ (NREQ),
        .RR   (RR)
    ) u_pick (
        .req  (src_valid),
        .ptr  (rr_ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    assign src_ready = (state == ST_FETCH) ? (src_valid & grant) : '0;
    assign accept    = |src_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            gnt_idx    <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            last_q     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|src_valid) begin
                        grant   <= pick_gnt;
                        gnt_idx <= pick_idx;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // a starved owner keeps the line; no re-arbitration mid-frame
                    if (accept) begin
                        tx_data  <= src_data[{gnt_idx, 3'b000} +: 8];
                        last_q   <= src_last[gnt_idx];
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy)
                        state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            frame_done <= 1'b1;
                            grant      <= '0;
                            gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                            state      <= ST_GAP;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-level model of
// arbitration order, per-source byte scripts and gap timing.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 2;
    localparam int GAP  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   src_valid, src_last, src_ready, grant;
    logic [8*NREQ-1:0] src_data;
    logic [7:0]        tx_data;
    logic              tx_start, tx_busy, frame_done;

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP),
        .GAP_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_last   (src_last),
        .src_ready  (src_ready),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // per-source frame scripts, owned by the test sequence
    logic [7:0] scr_byte [NREQ][$];
    bit         scr_last [NREQ][$];

    bit run = 1'b0;
    bit mon_en = 1'b0;
    bit busy_stuck = 1'b0;
    int stall_max = 0;
    int busy_dly_max = 0, busy_min = 10, busy_max = 10;
    int stall_once [NREQ];

    int drv_ptr [NREQ];
    int stall [NREQ];
    bit tx_pend = 1'b0;
    int tx_low = 0, tx_high = 0;

    int cyc = 0;
    int mon_ptr [NREQ];
    int n_start = 0, n_done = 0, ref_ptr = 0, last_done = -1000;
    bit exp_last = 1'b0;
    int order[$], gaps[$], rise_cyc[$], start_cyc[$], fall_cyc[$], done_cyc[$];
    logic [NREQ-1:0] p_valid = '0, p_ready = '0, p_grant = '0;
    logic p_start = 1'b0, p_done = 1'b0, p_busy = 1'b0;

    function automatic int ref_pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
            if (v[(ref_ptr + k) % NREQ]) return (ref_ptr + k) % NREQ;
`else
            if (v[k]) return k;
`endif
        end
        return -1;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic bit all_sent();
        for (int i = 0; i < NREQ; i++)
            if (mon_ptr[i] != scr_byte[i].size()) return 1'b0;
        return 1'b1;
    endfunction

    // sources and transmitter model, driven just after each rising edge
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (!run) begin
                drv_ptr[i] = 0;
                stall[i] = 0;
            end else if (p_valid[i] && p_ready[i]) begin
                drv_ptr[i]++;
                if (stall_once[i] > 0) begin
                    stall[i] = stall_once[i];
                    stall_once[i] = 0;
                end else begin
                    stall[i] = $urandom_range(stall_max, 0);
                end
            end else if (stall[i] > 0) begin
                stall[i]--;
            end
            if (run && stall[i] == 0 && drv_ptr[i] < scr_byte[i].size()) begin
                src_valid[i] = 1'b1;
                src_data[8*i +: 8] = scr_byte[i][drv_ptr[i]];
                src_last[i] = scr_last[i][drv_ptr[i]];
            end else begin
                src_valid[i] = 1'b0;
                src_data[8*i +: 8] = 8'h00;
                src_last[i] = 1'b0;
            end
        end
        if (!run) begin
            tx_pend = 1'b0;
            tx_busy = 1'b0;
        end else begin
            if (p_start) begin
                tx_pend = 1'b1;
                tx_low = $urandom_range(busy_dly_max, 0);
                tx_high = $urandom_range(busy_max, busy_min);
            end
            if (tx_pend && !busy_stuck) begin
                if (tx_low > 0) begin
                    tx_low--;
                    tx_busy = 1'b0;
                end else if (tx_high > 0) begin
                    tx_busy = 1'b1;
                    tx_high--;
                end else begin
                    tx_busy = 1'b0;
                    tx_pend = 1'b0;
                end
            end
        end
    end

    // monitor: checks every cycle against the frame-level model
    always @(negedge clk) begin
        int w;
        int g;
        cyc++;
        if (!mon_en) begin
            for (int i = 0; i < NREQ; i++) mon_ptr[i] = 0;
            n_start = 0;
            n_done = 0;
            ref_ptr = 0;
            last_done = -1000;
            exp_last = 1'b0;
            order.delete(); gaps.delete(); rise_cyc.delete();
            start_cyc.delete(); fall_cyc.delete(); done_cyc.delete();
        end else begin
            chk("ready_mask", 32'(src_ready & ~grant), 0);
            if (grant != 0 && p_grant != 0)
                chk("no_switch", 32'(grant), 32'(p_grant));
            if (grant != 0 && p_grant == 0) begin
                w = ref_pick(p_valid);
                chk("winner", 32'(grant), (w < 0) ? 0 : (1 << w));
                chk("gap_min", 32'(cyc - last_done >= GAP + 1), 1);
                gaps.push_back(cyc - last_done);
                order.push_back(w);
                rise_cyc.push_back(cyc);
                if (w >= 0) ref_ptr = (w + 1) % NREQ;
            end
            if (tx_start) begin
                chk("start_single", 32'(p_start), 0);
                chk("start_onehot", 32'($onehot(grant)), 1);
                g = 0;
                for (int k = 0; k < NREQ; k++) if (grant[k]) g = k;
                if (mon_ptr[g] < scr_byte[g].size()) begin
                    chk("tx_data", 32'(tx_data), 32'(scr_byte[g][mon_ptr[g]]));
                    exp_last = scr_last[g][mon_ptr[g]];
                    mon_ptr[g]++;
                end else begin
                    chk("extra_byte", 32'(g), 32'hFFFF);
                end
                n_start++;
                start_cyc.push_back(cyc);
            end
            if (p_busy && !tx_busy) fall_cyc.push_back(cyc);
            if (frame_done) begin
                chk("done_last", 32'(exp_last), 1);
                chk("done_grant0", 32'(grant), 0);
                chk("done_single", 32'(p_done), 0);
                chk("done_after_busy", cyc - at(fall_cyc, fall_cyc.size() - 1), 1);
                n_done++;
                last_done = cyc;
                done_cyc.push_back(cyc);
                exp_last = 1'b0;
            end
        end
        p_valid = src_valid;
        p_ready = src_ready;
        p_grant = grant;
        p_start = tx_start;
        p_done = frame_done;
        p_busy = tx_busy;
    end

    task automatic reset_dut(input string tag, input bit do_chk);
        rst = 1'b1;
        run = 1'b0;
        mon_en = 1'b0;
        busy_stuck = 1'b0;
        @(negedge clk);
        #1;
        if (do_chk) begin
            chk({tag, "_grant"}, 32'(grant), 0);
            chk({tag, "_ready"}, 32'(src_ready), 0);
            chk({tag, "_txdata"}, 32'(tx_data), 0);
            chk({tag, "_start"}, 32'(tx_start), 0);
            chk({tag, "_done"}, 32'(frame_done), 0);
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            scr_byte[i].delete();
            scr_last[i].delete();
            stall_once[i] = 0;
        end
        rst = 1'b0;
    endtask

    task automatic go();
        run = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic push(input int l, input logic [7:0] b, input bit last);
        scr_byte[l].push_back(b);
        scr_last[l].push_back(last);
    endtask

    task automatic rand_frame(input int l, input int len);
        for (int k = 0; k < len; k++)
            push(l, 8'($urandom_range(255, 0)), k == len - 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        while (!(all_sent() && grant == 0 && !tx_busy) && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({tag, "_timeout"}, 32'(t < budget), 1);
        repeat (GAP + 3) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] keep [3];
        int t;
        int nb;

        reset_dut("rst0", 1'b1);

        // 3-byte frame then a single-byte frame from the same source
        busy_dly_max = 0; busy_min = 10; busy_max = 10; stall_max = 0;
        push(0, 8'hA5, 1'b0);
        push(0, 8'h5A, 1'b0);
        push(0, 8'hFF, 1'b1);
        push(0, 8'h3C, 1'b1);
        go();
        wait_idle("s1", 1000);
        chk("s1_starts", n_start, 4);
        chk("s1_dones", n_done, 2);
        chk("s1_first_start", at(start_cyc, 0) - at(rise_cyc, 0), 1);
        chk("s1_refetch", at(start_cyc, 1) - at(fall_cyc, 0), 2);
        chk("s1_gap", at(gaps, 1), GAP + 1);
        chk("s1_single_done", at(done_cyc, 1) - at(fall_cyc, 3), 1);

        // both sources valid from reset release, 2-byte frames
        reset_dut("rst1", 1'b0);
        for (int f = 0; f < 3; f++) begin
            rand_frame(0, 2);
            rand_frame(1, 2);
        end
        go();
        wait_idle("s2", 2000);
        chk("s2_dones", n_done, 6);
        chk("s2_order0", at(order, 0), 0);
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
        chk("s2_order1", at(order, 1), 1);
`else
        chk("s2_order1", at(order, 1), 0);
`endif
        chk("s2_order2", at(order, 2), 0);
        chk("s2_order3", at(order, 3), 1);
        chk("s2_gap", at(gaps, 1), GAP + 1);

        // owner starves 50 cycles mid-frame while the other source waits
        reset_dut("rst2", 1'b0);
        rand_frame(0, 3);
        rand_frame(1, 2);
        stall_once[0] = 50;
        go();
        wait_idle("s3", 2000);
        chk("s3_owner", at(order, 0), 0);
        chk("s3_stall", 32'(at(start_cyc, 1) - at(start_cyc, 0) >= 50), 1);
        chk("s3_second", at(order, 1), 1);
        chk("s3_wait_gap", at(rise_cyc, 1) - at(done_cyc, 0), GAP + 1);

        // reset while byte 2 is in WAIT_DONE, then restart the frame
        reset_dut("rst3", 1'b0);
        rand_frame(0, 3);
        for (int k = 0; k < 3; k++) keep[k] = scr_byte[0][k];
        go();
        t = 0;
        while (!(n_start >= 2 && tx_busy) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("s4_reach", 32'(t < 500), 1);
        @(negedge clk);
        #1;
        reset_dut("s4_rst", 1'b1);
        for (int k = 0; k < 3; k++) push(0, keep[k], k == 2);
        go();
        wait_idle("s4", 1000);
        chk("s4_starts", n_start, 3);
        chk("s4_dones", n_done, 1);

        // transmitter never raises busy: no re-pulse, grant held
        reset_dut("rst4", 1'b0);
        rand_frame(0, 2);
        busy_stuck = 1'b1;
        go();
        t = 0;
        while (n_start < 1 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("s5_reach", 32'(t < 200), 1);
        repeat (20) @(negedge clk);
        #1;
        chk("s5_starts", n_start, 1);
        chk("s5_grant", 32'(grant), 1);
        chk("s5_ready", 32'(src_ready), 0);
        busy_stuck = 1'b0;
        wait_idle("s5", 500);
        chk("s5_final", n_start, 2);

        // randomized traffic with stalls and variable busy timing
        reset_dut("rst5", 1'b0);
        nb = 0;
        for (int f = 0; f < 4; f++) begin
            for (int l = 0; l < NREQ; l++) begin
                t = $urandom_range(4, 1);
                rand_frame(l, t);
                nb += t;
            end
        end
        stall_max = 3; busy_dly_max = 3; busy_min = 1; busy_max = 6;
        go();
        wait_idle("s6", 5000);
        chk("s6_dones", n_done, 4 * NREQ);
        chk("s6_starts", n_start, nb);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between NREQ byte-stream sources, such as the game-state frame builder and the handshake/lobby sender. It arbitrates at frame granularity: a winning source keeps the transmitter until its last byte has left the line, so no two frames ever interleave. It replaces fixed-delay byte pacing with a start/busy handshake to the transmitter and inserts a programmable idle gap between frames so the receiver can resynchronise. It sits between the frame builders and the UART TX core.

## Interface
Parameters:
- NREQ, 2: number of sources (2..8).
- GAP_CYCLES, 1000: idle clk cycles inserted after each frame (≥1).
- GAP_W, 16: width of the gap counter; GAP_CYCLES < 2^GAP_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- src_valid  in  NREQ  source i has a byte on its data lane.
- src_data  in  8*NREQ  byte lanes; lane i = bits [8i+7:8i].
- src_last  in  NREQ  lane i byte is the final byte of its frame.
- src_ready  out  NREQ  combinational; byte on lane i accepted this cycle.
- grant  out  NREQ  registered one-hot owner of the transmitter; 0 when free.
- tx_data  out  8  byte to transmitter; held stable from START until the next FETCH accept.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter shifting a byte.
- frame_done  out  1  one-cycle pulse when the last byte of a frame finishes.

## Operation
States: IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any src_valid, pick a winner (see Configuration), register grant, go to FETCH. Otherwise stay, with grant=0.
- FETCH: src_ready[g] = src_valid[g] for the granted g only; all other src_ready bits are 0.
  - On accept, latch tx_data ← lane g and last_q ← src_last[g], then go to START.
  - If src_valid[g]=0, stay in FETCH and keep the grant. Mid-frame starvation never releases the transmitter.
- START: tx_start=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. tx_start is not re-pulsed.
- WAIT_DONE: wait for tx_busy=0.
  - If last_q=1: pulse frame_done, clear grant, load gap counter with GAP_CYCLES-1, go to GAP.
  - Otherwise go to FETCH.
- GAP: decrement the counter; at 0 go to IDLE. Source requests are ignored during GAP.
- src_valid changes on non-granted lanes never affect the current frame.
- A single-byte frame (src_last set on the first byte) is legal.
- Reset mid-frame: next cycle state=IDLE and every output is 0. The partially sent frame is abandoned, and the source must restart it.

## Timing
Reset values: tx_data=0, tx_start=0, grant=0, src_ready=0, frame_done=0, state=IDLE, rr pointer=0, gap counter=0.

Cycle counts:
- src_valid rising in IDLE → grant at +1 → src_ready at +1 (same cycle as grant, combinational) → tx_start at +2.
- tx_busy falling on a non-last byte → next src_ready at +1 → tx_start at +2 (if valid held).
- Last byte: frame_done is asserted in the cycle after tx_busy is sampled low, and grant is 0 in that same cycle.
- Earliest next grant is GAP_CYCLES+1 cycles after frame_done.

Handshakes:
- Source side: a byte transfers when src_valid & src_ready are both high on the same clk edge. Sources must hold data and last stable while valid is high.
- Transmitter side: tx_busy must rise within finite time after tx_start; there is no timeout.

## Configuration
- UART_TX_ARB_ROUND_ROBIN_EN defined: round-robin. Search starts at rr_ptr; on grant, rr_ptr ← g+1 mod NREQ.
- Undefined: fixed priority, lowest index wins; rr_ptr is not implemented.
- In both modes, a grant lasts exactly one frame.

## Structure
- Shared package/header (uart_pkg): state encodings, default GAP_CYCLES, and the frame-gap constant tied to the baud rate.
- Sub-module uart_arb_pick: combinational one-hot picker taking req, rr_ptr and the mode.
  - Outputs the one-hot grant and its index.
  - Reused by the RX dispatcher.
- The FSM, latches and gap counter live in uart_tx_arbiter itself.

## Test plan
- Single source, 3-byte frame A5,5A,FF (last on FF), tx_busy model high for 10 cycles per byte:
  - Expect exactly 3 tx_start pulses, tx_data in that order, and frame_done once.
  - Expect grant=0 for GAP_CYCLES cycles afterwards.
- Sources 0 and 1 both valid from reset release, with 2-byte frames:
  - Round-robin: order src0, src1, src0.
  - Fixed priority: src0 repeatedly, src1 starved while src0 stays valid.
- Src0 drops src_valid for 50 cycles between bytes while src1 is valid:
  - grant stays at 01 and no src1 byte is accepted.
  - The frame then completes normally.
- Single-byte frame 0x3C with src_last=1 → one tx_start, then frame_done 1 cycle after tx_busy falls.
- Reset asserted during WAIT_DONE of byte 2:
  - Next cycle all outputs are 0.
  - After release, a new frame starts from byte 1 with no stray tx_start.
- tx_busy held low 20 cycles after tx_start → no second tx_start and the FSM stays in WAIT_BUSY.
